// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Soft-start / soft-stop sequencer for an 8-bit pwm generator. Owns the
// pwm duty and period inputs and walks duty toward a commanded target in
// fixed steps. Every change lands on a PWM period boundary. An internal
// period counter runs in lock-step with the pwm counter.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   cfg_valid      : new target offered
//   cfg_ready      : target can be accepted (IDLE/HOLD and no stop)
//   cfg_duty       : target duty
//   cfg_period     : target period (0 treated as 1)
//   cfg_step       : duty change per step (0 treated as 1)
//   cfg_div        : period ticks per step (0 treated as 1)
//   stop           : ramp duty down to 0, then go idle
//   duty, period   : drive pwm.duty / pwm.period
//   period_tick    : last cycle of each PWM period
//   busy           : ramping (RAMP or STOP)
//   done           : one-cycle pulse when a ramp completes
module pwm_ramp_ctrl #(
    parameter logic [7:0] PERIOD_RST = 8'd220
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_duty,
    input  logic [7:0] cfg_period,
    input  logic [7:0] cfg_step,
    input  logic [7:0] cfg_div,
    input  logic       stop,
    output logic [7:0] duty,
    output logic [7:0] period,
    output logic       period_tick,
    output logic       busy,
    output logic       done
);

    localparam int DATA_W = 8;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD,
        S_STOP
    } state_t;

    state_t state, state_n;

    word_t cnt, cnt_n;
    word_t period_eff;
    word_t duty_n, period_n;
    word_t dcnt, dcnt_n, dcnt_dec;
    word_t duty_c, duty_s;
    word_t tgt_period, tgt_duty, step, div;
    logic  done_n;
    logic  accept;
    logic  ld_cfg, ld_stop;

    // Zero means "one" for period, step and divider.
    function automatic word_t nz(input word_t v);
        return (v == '0) ? 8'd1 : v;
    endfunction

    function automatic word_t min_w(input word_t a, input word_t b);
        return (a < b) ? a : b;
    endfunction

    // Upward step, summed one bit wider so it can never wrap past lim.
    function automatic word_t sat_up(input word_t cur, input word_t stp, input word_t lim);
        logic [DATA_W:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        return (sum > {1'b0, lim}) ? lim : sum[DATA_W-1:0];
    endfunction

    // Downward step; caller guarantees cur >= lim, so cur - lim cannot underflow.
    function automatic word_t sat_dn(input word_t cur, input word_t stp, input word_t lim);
        return ((cur - lim) > stp) ? (cur - stp) : lim;
    endfunction

    assign busy      = (state == S_RAMP) || (state == S_STOP);
    assign cfg_ready = ((state == S_IDLE) || (state == S_HOLD)) && !stop;
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        state_n  = state;
        duty_n   = duty;
        period_n = period;
        dcnt_n   = dcnt;
        done_n   = 1'b0;
        ld_cfg   = 1'b0;
        ld_stop  = 1'b0;
        duty_s   = duty;

        period_eff  = (period == '0) ? 8'd1 : period;
        period_tick = (cnt == period_eff - 8'd1);
        cnt_n       = period_tick ? '0 : cnt + 8'd1;

        // A period shrink clamps duty on every tick, not just on step ticks.
        duty_c   = min_w(duty, tgt_period);
        dcnt_dec = dcnt - 8'd1;

        if (stop && ((state == S_RAMP) || (state == S_HOLD))) begin
            ld_stop = 1'b1;
            dcnt_n  = div;
            state_n = S_STOP;
        end else if (accept) begin
            ld_cfg  = 1'b1;
            dcnt_n  = nz(cfg_div);
            state_n = S_RAMP;
        end else if (period_tick && busy) begin
            period_n = tgt_period;
            duty_n   = duty_c;
            dcnt_n   = dcnt_dec;
            if (dcnt_dec == '0) begin
                dcnt_n = div;
                duty_s = (duty_c < tgt_duty) ? sat_up(duty_c, step, tgt_duty)
                                             : sat_dn(duty_c, step, tgt_duty);
                duty_n = duty_s;
                if (duty_s == tgt_duty) begin
                    done_n  = 1'b1;
                    state_n = (state == S_RAMP) ? S_HOLD : S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            duty   <= '0;
            period <= PERIOD_RST;
            dcnt   <= 8'd1;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            duty   <= duty_n;
            period <= period_n;
            dcnt   <= dcnt_n;
            done   <= done_n;
        end
    end

    // Target registers are only meaningful once loaded by an accept.
    always_ff @(posedge clk) begin
        if (ld_cfg) begin
            tgt_period <= nz(cfg_period);
            tgt_duty   <= min_w(cfg_duty, nz(cfg_period));
            step       <= nz(cfg_step);
            div        <= nz(cfg_div);
        end else if (ld_stop) begin
            tgt_duty <= '0;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_duty = '0;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_step = '0;
    logic [7:0] cfg_div = '0;
    logic       stop = 1'b0;
    logic [7:0] duty;
    logic [7:0] period;
    logic       period_tick;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    pwm_ramp_ctrl #(.PERIOD_RST(8'd220)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_duty(cfg_duty), .cfg_period(cfg_period),
        .cfg_step(cfg_step), .cfg_div(cfg_div),
        .stop(stop),
        .duty(duty), .period(period),
        .period_tick(period_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] duty;
        logic [7:0] period;
        logic       tick;
        logic       busy;
        logic       done;
        logic       ready;
    } obs_t;

    obs_t expq[$];

    // Reference model: mode names and plain integer arithmetic.
    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_STOP = 3;

    int m_state, m_cnt, m_duty, m_period, m_tp, m_td, m_step, m_div, m_dcnt;
    bit m_done;
    bit m_known = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step();
        obs_t e;
        int   plen;
        bit   tk, rdy, ramping;
        int   d;
        plen    = imax(m_period, 1);
        tk      = (m_cnt == plen - 1);
        rdy     = (m_state == M_IDLE || m_state == M_HOLD) && !stop;
        ramping = (m_state == M_RAMP || m_state == M_STOP);
        if (m_known) begin
            e.duty   = 8'(m_duty);
            e.period = 8'(m_period);
            e.tick   = tk;
            e.busy   = ramping;
            e.done   = m_done;
            e.ready  = rdy;
            expq.push_back(e);
        end
        if (rst) begin
            m_state = M_IDLE; m_cnt = 0; m_duty = 0; m_period = 220;
            m_done = 0; m_known = 1;
            return;
        end
        m_done = 0;
        m_cnt  = tk ? 0 : m_cnt + 1;
        if (stop && (m_state == M_RAMP || m_state == M_HOLD)) begin
            m_td = 0; m_dcnt = m_div; m_state = M_STOP;
        end else if (rdy && cfg_valid) begin
            m_tp   = imax(int'(cfg_period), 1);
            m_td   = imin(int'(cfg_duty), m_tp);
            m_step = imax(int'(cfg_step), 1);
            m_div  = imax(int'(cfg_div), 1);
            m_dcnt = m_div;
            m_state = M_RAMP;
        end else if (tk && ramping) begin
            m_period = m_tp;
            d = imin(m_duty, m_tp);
            m_dcnt = m_dcnt - 1;
            if (m_dcnt == 0) begin
                m_dcnt = m_div;
                if (d < m_td) d = imin(d + m_step, m_td);
                else          d = imax(d - m_step, m_td);
                if (d == m_td) begin
                    m_done = 1;
                    m_state = (m_state == M_RAMP) ? M_HOLD : M_IDLE;
                end
            end
            m_duty = d;
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit s,
                         input int cd, input int cp, input int cs, input int cdv);
        @(negedge clk);
        rst = r; cfg_valid = v; stop = s;
        cfg_duty = 8'(cd); cfg_period = 8'(cp); cfg_step = 8'(cs); cfg_div = 8'(cdv);
        model_step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int cd, input int cp, input int cs, input int cdv);
        drive(0, 1, 0, cd, cp, cs, cdv);
    endtask

    // Let the last driven edge take effect before reading registered outputs.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_until_state(input string name, input int st, input int maxc);
        int c = 0;
        while (m_state != st && c < maxc) begin
            idle();
            c++;
        end
        check_val({name, "_reached"}, int'(m_state == st), 1);
    endtask

    task automatic run_until_duty(input string name, input int dv, input int maxc);
        int c = 0;
        while (m_duty != dv && c < maxc) begin
            idle();
            c++;
        end
        check_val({name, "_reached"}, int'(m_duty == dv), 1);
    endtask

    // Monitor: one observation per cycle, compared against the scoreboard.
    initial begin
        obs_t e, a;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a.duty = duty; a.period = period; a.tick = period_tick;
                a.busy = busy; a.done = done; a.ready = cfg_ready;
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL cycle%0d outputs: got duty=%0d period=%0d tick=%0b busy=%0b done=%0b ready=%0b, expected duty=%0d period=%0d tick=%0b busy=%0b done=%0b ready=%0b",
                             cyc, a.duty, a.period, a.tick, a.busy, a.done, a.ready,
                             e.duty, e.period, e.tick, e.busy, e.done, e.ready);
                end
            end
        end
    end

    initial begin
        int first_tick;
        bit r, v, s;
        int cd, cp, cs, cdv;

        // Reset
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        settle();
        check_val("rst_duty", duty, 0);
        check_val("rst_period", period, 220);
        check_val("rst_ready", cfg_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        first_tick = -1;
        for (int i = 0; i < 300 && first_tick < 0; i++) begin
            idle();
            if (period_tick) first_tick = i;
        end
        check_val("first_tick_cycle", first_tick, 219);

        // Ramp up 0 -> 64
        cfg(64, 220, 16, 1);
        run_until_state("ramp_up", M_HOLD, 2000);
        settle();
        check_val("ramp_up_duty", duty, 64);
        check_val("ramp_up_done", done, 1);
        check_val("ramp_up_busy", busy, 0);

        // Saturating up 64 -> 110
        cfg(110, 220, 50, 2);
        run_until_state("sat_up", M_HOLD, 2000);
        settle();
        check_val("sat_up_duty", duty, 110);

        // Down 110 -> 10
        cfg(10, 220, 40, 1);
        run_until_state("ramp_dn", M_HOLD, 2000);
        settle();
        check_val("ramp_dn_duty", duty, 10);

        // Back to 110/220, then shrink the period below duty
        cfg(110, 220, 200, 1);
        run_until_state("back_up", M_HOLD, 2000);
        cfg(200, 100, 8, 3);
        run_until_state("shrink", M_HOLD, 2000);
        settle();
        check_val("shrink_period", period, 100);
        check_val("shrink_duty", duty, 100);

        // Stop mid-ramp at 48
        cfg(0, 100, 255, 1);
        run_until_state("to_zero", M_HOLD, 2000);
        cfg(96, 100, 16, 1);
        run_until_duty("ramp_48", 48, 2000);
        drive(0, 0, 1, 0, 0, 0, 0);
        run_until_state("stop", M_IDLE, 2000);
        settle();
        check_val("stop_duty", duty, 0);
        check_val("stop_done", done, 1);
        check_val("stop_busy", busy, 0);

        // stop together with cfg_valid, and stop in IDLE
        drive(0, 1, 1, 50, 100, 1, 1);
        settle();
        check_val("stop_cfg_busy", busy, 0);
        check_val("stop_cfg_duty", duty, 0);

        // step 0 / div 0 treated as 1
        cfg(3, 100, 0, 0);
        run_until_state("step0", M_HOLD, 2000);
        settle();
        check_val("step0_duty", duty, 3);

        // period 0 treated as 1
        cfg(3, 0, 1, 1);
        run_until_state("per0", M_HOLD, 2000);
        for (int i = 0; i < 5; i++) begin
            idle();
            check_val("per0_tick", period_tick, 1);
        end
        check_val("per0_period", period, 1);

        // Reset mid-ramp
        cfg(200, 50, 1, 1);
        for (int i = 0; i < 120; i++) idle();
        drive(1, 0, 0, 0, 0, 0, 0);
        settle();
        check_val("midrst_duty", duty, 0);
        check_val("midrst_period", period, 220);
        check_val("midrst_busy", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 20000; i++) begin
            r   = ($urandom_range(0, 2999) == 0);
            v   = ($urandom_range(0, 7) == 0);
            s   = ($urandom_range(0, 63) == 0);
            cd  = $urandom_range(0, 255);
            cp  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            cs  = $urandom_range(0, 60);
            cdv = $urandom_range(0, 3);
            drive(r, v, s, cd, cp, cs, cdv);
        end
        idle();
        #5;
        check_val("scoreboard_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
